maxpool_2x2: RTL and testbench

MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

---
 rtl/maxpool_2x2.sv | 185 ++++++++++++++++++
 tb/tb_maxpool_2x2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max-pooling engine: reads R and CH from a parameter SRAM, pools each
// R x R channel plane of the conv-output SRAM and writes the pooled words contiguously.
module maxpool_2x2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        param_cs,
  output logic [31:0] param_addr,
  input  logic [31:0] param_rdata,
  output logic        in_cs,
  output logic [31:0] in_addr,
  input  logic [31:0] in_rdata,
  output logic        out_cs,
  output logic        out_web,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata
);

  typedef enum logic [2:0] {IDLE, LD_PARM, RD, WR, FIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  num_row_q, num_row_d;
  logic [8:0]  num_ch_q, num_ch_d;
  logic [4:0]  q_q, q_d;
  logic [4:0]  r_q, r_d;
  logic [8:0]  c_q, c_d;
  logic [31:0] chan_base_q, chan_base_d;
  logic [31:0] row_base_q, row_base_d;
  logic [31:0] out_idx_q, out_idx_d;
  logic [7:0]  max_q, max_d;

  logic [4:0]  pool_dim;
  logic [31:0] row_words;
  logic [31:0] plane_words;
  logic [31:0] pix_base;
  logic [7:0]  px;
  logic        last_q, last_r, last_c;
  logic        unused_bits;

  assign pool_dim    = num_row_q[5:1];
  assign row_words   = {26'd0, num_row_q};
  assign plane_words = row_words * row_words;
  // Top-left corner of the current 2x2 window.
  assign pix_base    = row_base_q + {26'd0, q_q, 1'b0};
  assign px          = in_rdata[7:0];
  assign last_q      = (q_q == pool_dim - 5'd1);
  assign last_r      = (r_q == pool_dim - 5'd1);
  assign last_c      = (c_q == num_ch_q - 9'd1);
  assign unused_bits = ^{in_rdata[31:8], param_rdata[31:9]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_row_d   = num_row_q;
    num_ch_d    = num_ch_q;
    q_d         = q_q;
    r_d         = r_q;
    c_d         = c_q;
    chan_base_d = chan_base_q;
    row_base_d  = row_base_q;
    out_idx_d   = out_idx_q;
    max_d       = max_q;
    finish      = 1'b0;
    param_cs    = 1'b0;
    param_addr  = 32'd0;
    in_cs       = 1'b0;
    in_addr     = 32'd0;
    out_cs      = 1'b0;
    out_web     = 1'b1;
    out_addr    = 32'd0;
    out_wdata   = 32'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LD_PARM;
          cnt_d   = 3'd0;
        end
      end

      LD_PARM: begin
        param_cs   = 1'b1;
        param_addr = (cnt_q == 3'd0) ? 32'd0 : 32'd1;
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd1) num_row_d = param_rdata[5:0];
        if (cnt_q == 3'd2) begin
          num_ch_d    = param_rdata[8:0];
          cnt_d       = 3'd0;
          q_d         = 5'd0;
          r_d         = 5'd0;
          c_d         = 9'd0;
          chan_base_d = 32'd0;
          row_base_d  = 32'd0;
          out_idx_d   = 32'd0;
          // Degenerate geometry produces no pixels at all.
          if (num_row_q < 6'd2 || param_rdata[8:0] == 9'd0) state_d = FIN;
          else                                                state_d = RD;
        end
      end

      RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q <= 3'd3) begin
          in_cs = 1'b1;
          case (cnt_q)
            3'd0:    in_addr = pix_base;
            3'd1:    in_addr = pix_base + 32'd1;
            3'd2:    in_addr = pix_base + row_words;
            default: in_addr = pix_base + row_words + 32'd1;
          endcase
        end
        // Data lags its address by one cycle; the first sample seeds the max.
        if (cnt_q == 3'd1)                     max_d = px;
        else if (cnt_q != 3'd0 && px > max_q)  max_d = px;
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          state_d = WR;
        end
      end

      WR: begin
        out_cs    = 1'b1;
        out_web   = 1'b0;
        out_addr  = out_idx_q;
        out_wdata = {24'h0, max_q};
        out_idx_d = out_idx_q + 32'd1;
        if (last_q) begin
          q_d = 5'd0;
          if (last_r) begin
            r_d         = 5'd0;
            c_d         = c_q + 9'd1;
            chan_base_d = chan_base_q + plane_words;
            row_base_d  = chan_base_q + plane_words;
          end else begin
            r_d        = r_q + 5'd1;
            row_base_d = row_base_q + {row_words[30:0], 1'b0};
          end
        end else begin
          q_d = q_q + 5'd1;
        end
        state_d = (last_q && last_r && last_c) ? FIN : RD;
      end

      FIN: begin
        finish  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      num_row_q   <= 6'd0;
      num_ch_q    <= 9'd0;
      q_q         <= 5'd0;
      r_q         <= 5'd0;
      c_q         <= 9'd0;
      chan_base_q <= 32'd0;
      row_base_q  <= 32'd0;
      out_idx_q   <= 32'd0;
      max_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_row_q   <= num_row_d;
      num_ch_q    <= num_ch_d;
      q_q         <= q_d;
      r_q         <= r_d;
      c_q         <= c_d;
      chan_base_q <= chan_base_d;
      row_base_q  <= row_base_d;
      out_idx_q   <= out_idx_d;
      max_q       <= max_d;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Table-driven bench for maxpool_2x2: SRAM models, a scoreboard of expected writes
// from an independent pooling model, and hand-written reset-abort sequence.
module tb_maxpool_2x2;

  logic        clk = 1'b0;
  logic        rst, start, finish;
  logic        param_cs, in_cs, out_cs, out_web;
  logic [31:0] param_addr, param_rdata, in_addr, in_rdata, out_addr, out_wdata;

  always #5 clk = ~clk;

  maxpool_2x2 dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .param_cs(param_cs), .param_addr(param_addr), .param_rdata(param_rdata),
    .in_cs(in_cs), .in_addr(in_addr), .in_rdata(in_rdata),
    .out_cs(out_cs), .out_web(out_web), .out_addr(out_addr), .out_wdata(out_wdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM models with one-cycle read latency; upper data bits carry junk.
  logic [7:0] in_mem  [256];
  logic [7:0] out_mem [64];
  logic [5:0] cfg_row;
  logic [8:0] cfg_ch;

  always @(posedge clk) begin
    if (param_cs)
      param_rdata <= (param_addr == 32'd0) ? {16'hBEEF, 10'd0, cfg_row} : {16'hCAFE, 7'd0, cfg_ch};
    if (in_cs)
      in_rdata <= {24'hC3A5F0, (in_addr < 32'd256) ? in_mem[in_addr[7:0]] : 8'h00};
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int rd_count, wr_count, pcs_count, region_bad, cs_bad;
  int cur_row, cur_ch;

  function automatic bit in_region(input logic [31:0] a);
    int p, col, row, ai;
    ai  = int'(a);
    p   = cur_row / 2;
    col = ai % cur_row;
    row = (ai / cur_row) % cur_row;
    return (col < 2 * p) && (row < 2 * p) && (ai < cur_ch * cur_row * cur_row);
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (param_cs) pcs_count++;
      if (in_cs) begin
        rd_count++;
        if (cur_row < 2 || !in_region(in_addr)) region_bad++;
      end
      if ((!out_web && !out_cs) || (in_cs && out_cs) || (param_cs && (in_cs || out_cs))) cs_bad++;
      if (out_cs && !out_web) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", out_addr, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wr_addr[%0d]", e.addr), out_addr, e.addr);
          check($sformatf("wr_data[%0d]", e.addr), out_wdata, {24'h0, e.data});
        end
        if (out_addr < 32'd64) out_mem[out_addr[5:0]] = out_wdata[7:0];
      end
    end
  end

  // Independent reference: direct nested loops over the stored image.
  task automatic push_expected(input int r, input int ch);
    int p, idx, base;
    logic [7:0] m;
    p   = r / 2;
    idx = 0;
    exp_q.delete();
    if (r < 2) return;
    for (int c = 0; c < ch; c++)
      for (int rr = 0; rr < p; rr++)
        for (int q = 0; q < p; q++) begin
          base = c * r * r + 2 * rr * r + 2 * q;
          m = in_mem[base];
          if (in_mem[base + 1] > m)     m = in_mem[base + 1];
          if (in_mem[base + r] > m)     m = in_mem[base + r];
          if (in_mem[base + r + 1] > m) m = in_mem[base + r + 1];
          exp_q.push_back('{addr: 32'(idx), data: m});
          idx++;
        end
  endtask

  task automatic fill(input int r, input int ch, input int pat);
    for (int i = 0; i < 256; i++)
      in_mem[i] = (pat == 0) ? 8'(i & 127) : 8'($urandom_range(0, 127));
    if (pat == 1) begin
      for (int c = 0; c < ch; c++)
        for (int i = 0; i < r * r; i++) in_mem[c * r * r + i] = 8'(16 + c);
      if (ch > 1) in_mem[r * r + 3] = 8'h7F;
    end
    for (int i = 0; i < 64; i++) out_mem[i] = 8'hEE;
  endtask

  task automatic clear_counts();
    rd_count = 0; wr_count = 0; pcs_count = 0; region_bad = 0; cs_bad = 0;
  endtask

  // Latency = cycles from the start-pulse cycle to the finish cycle, both inclusive.
  task automatic run_pass(input int r, input int ch, input bit spam, output int lat);
    int  start_cyc;
    bit  done;
    cfg_row = 6'(r);
    cfg_ch  = 9'(ch);
    cur_row = r;
    cur_ch  = ch;
    clear_counts();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    done  = 1'b0;
    lat   = -1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (finish) begin
        done = 1'b1;
        lat  = cyc - start_cyc + 1;
      end else begin
        start = spam && (i % 3 == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!done) check("finish_timeout", 0, 1);
    @(negedge clk);
    check("finish_one_cycle", finish, 0);
  endtask

  typedef struct {
    int               row;
    int               ch;
    int               pat;
    bit               spam;
    int               n_wr;
    int               lat;
    int               n_const;
    logic [3:0][7:0]  k;
  } vec_t;

  vec_t vt [10];

  initial begin
    int lat, n_wr0, n_rd0;

    //          row ch pat spam n_wr lat  nk  {w3,w2,w1,w0}
    vt[0] = '{4, 1, 0, 1'b0, 4,  29,  4, {8'd15, 8'd13, 8'd7,  8'd5}};
    vt[1] = '{2, 3, 1, 1'b0, 3,  23,  3, {8'h00, 8'h12, 8'h7F, 8'h10}};
    vt[2] = '{5, 1, 0, 1'b0, 4,  29,  4, {8'd18, 8'd16, 8'd8,  8'd6}};
    vt[3] = '{0, 1, 0, 1'b0, 0,  5,   0, 32'd0};
    vt[4] = '{1, 4, 0, 1'b0, 0,  5,   0, 32'd0};
    vt[5] = '{4, 0, 0, 1'b0, 0,  5,   0, 32'd0};
    vt[6] = '{3, 2, 2, 1'b0, 2,  17,  0, 32'd0};
    vt[7] = '{6, 2, 2, 1'b1, 18, 113, 0, 32'd0};
    vt[8] = '{4, 1, 0, 1'b1, 4,  29,  4, {8'd15, 8'd13, 8'd7,  8'd5}};
    vt[9] = '{4, 2, 2, 1'b0, 8,  53,  0, 32'd0};

    rst     = 1'b0;
    start   = 1'b0;
    cfg_row = 6'd0;
    cfg_ch  = 9'd0;
    cur_row = 0;
    cur_ch  = 0;
    clear_counts();
    #1;
    check("rst_finish",     finish,     0);
    check("rst_param_cs",   param_cs,   0);
    check("rst_param_addr", param_addr, 0);
    check("rst_in_cs",      in_cs,      0);
    check("rst_in_addr",    in_addr,    0);
    check("rst_out_cs",     out_cs,     0);
    check("rst_out_web",    out_web,    1);
    check("rst_out_addr",   out_addr,   0);
    check("rst_out_wdata",  out_wdata,  0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      fill(vt[v].row, vt[v].ch, vt[v].pat);
      push_expected(vt[v].row, vt[v].ch);
      run_pass(vt[v].row, vt[v].ch, vt[v].spam, lat);
      check($sformatf("v%0d_latency", v),   lat,        vt[v].lat);
      check($sformatf("v%0d_writes", v),    wr_count,   vt[v].n_wr);
      check($sformatf("v%0d_reads", v),     rd_count,   4 * vt[v].n_wr);
      check($sformatf("v%0d_param_cs", v),  pcs_count,  3);
      check($sformatf("v%0d_region", v),    region_bad, 0);
      check($sformatf("v%0d_cs_excl", v),   cs_bad,     0);
      check($sformatf("v%0d_sb_empty", v),  exp_q.size(), 0);
      for (int j = 0; j < vt[v].n_const; j++)
        check($sformatf("v%0d_out%0d", v, j), out_mem[j], vt[v].k[j]);
    end

    // Reset during the third pixel's read phase, then a clean rerun.
    fill(4, 2, 2);
    push_expected(4, 2);
    cfg_row = 6'd4;
    cfg_ch  = 9'd2;
    cur_row = 4;
    cur_ch  = 2;
    clear_counts();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && wr_count < 2; i++) @(negedge clk);
    check("abort_reach_rd3", wr_count, 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_web", out_web, 1);
    check("abort_out_cs",  out_cs,  0);
    check("abort_in_cs",   in_cs,   0);
    check("abort_finish",  finish,  0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    n_wr0 = wr_count;
    n_rd0 = rd_count;
    repeat (20) @(negedge clk);
    check("abort_no_write", wr_count, n_wr0);
    check("abort_idle",     rd_count, n_rd0);

    push_expected(4, 2);
    run_pass(4, 2, 1'b0, lat);
    check("rerun_latency", lat,          53);
    check("rerun_writes",  wr_count,     8);
    check("rerun_reads",   rd_count,     32);
    check("rerun_sb",      exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
